mem_bus_arbiter: RTL
====================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single external memory port between instruction fetch (IF) and data access (MEM stage).
//  Serialises requests, applies fixed MEM-over-IF priority and returns read data with one-cycle acks.
//  Drives the per-stage stall signals consumed by pipeline control.
// PARAMETERS
//  TIMEOUT_CYCLES  256  max cycles in a BUSY state before a bus error (BUS_TIMEOUT_EN only); >=2
// PORTS
//  clk          in   1   single clock, all state on rising edge
//  rst          in   1   asynchronous, active-high reset
//  if_req       in   1   IF fetch request, held until if_ack_o
//  if_addr      in   32  fetch address
//  if_flush     in   1   IF stage flushed; suppress pending fetch result
//  if_rdata_o   out  32  fetched instruction, valid with if_ack_o
//  if_ack_o     out  1   one-cycle fetch completion
//  if_err_o     out  1   fetch bus error, valid with if_ack_o
//  mem_req      in   1   MEM access request, held until mem_ack_o
//  mem_we       in   1   1=write, 0=read
//  mem_sel      in   4   byte enables
//  mem_addr     in   32  data address
//  mem_wdata    in   32  write data
//  mem_rdata_o  out  32  read data, valid with mem_ack_o
//  mem_ack_o    out  1   one-cycle access completion
//  mem_err_o    out  1   data bus error, valid with mem_ack_o
//  bus_req_o    out  1   external request, held until bus_ack
//  bus_we_o     out  1   external write enable
//  bus_sel_o    out  4   external byte enables (4'b1111 for fetch)
//  bus_addr_o   out  32  external address
//  bus_wdata_o  out  32  external write data
//  bus_rdata    in   32  external read data, valid with bus_ack
//  bus_ack      in   1   external completion
//  stall_if_o   out  1   comb: if_req & ~if_ack_o
//  stall_mem_o  out  1   comb: mem_req & ~mem_ack_o
// BEHAVIOUR
//  - FSM states: IDLE, BUSY_IF, BUSY_MEM, RESP. All bus_*/ack/rdata/err outputs registered.
//  - Reset (async): state=IDLE. All outputs 0: bus_*, acks, errs, rdata. Internal flush_pend=0, counter=0.
//  - IDLE: if mem_req goto BUSY_MEM, else if if_req goto BUSY_IF.
//    On the grant edge, latch addr/we/sel/wdata into bus_*_o and set bus_req_o=1.
//    A fetch is latched with we=0 and sel=4'b1111.
//  - Priority is fixed to MEM when both requests are high in the same IDLE cycle. IF waits.
//  - BUSY_x: hold bus_*_o stable until bus_ack=1. On that edge: bus_req_o<=0, capture bus_rdata
//    (writes return 0), goto RESP.
//  - RESP: exactly one cycle. Pulse the granted stage's ack_o=1 with its rdata_o/err_o, then goto IDLE.
//    rdata_o holds its value until the next ack. ack_o is 0 in all other states.
//  - Requesters drop req in the ack cycle. Req is only sampled in IDLE, so no double issue.
//  - Latency: req at cycle 0 with zero-wait bus (bus_ack in cycle 1) gives ack at cycle 2 and IDLE at cycle 3.
//    Back-to-back throughput is one access per 3 cycles.
//  - if_flush while IF is in BUSY_IF: set flush_pend. The bus transaction completes normally.
//    In RESP, if_ack_o is suppressed (stays 0) and flush_pend clears.
//  - if_flush in IDLE or RESP has no effect on the current transaction. A flushed IF must drop if_req.
//  - bus_ack while in IDLE/RESP is ignored (spurious).
//  - Reset mid-transaction aborts immediately: bus_req_o drops and no ack is issued.
//    The slave must tolerate abandonment.
//  - Simultaneous mem_req rise and IF ack in RESP: mem is granted at the next IDLE cycle.
// CONFIGURATION
//  - BUS_TIMEOUT_EN defined:
//    - 8+-bit counter clears on entry to BUSY_x and increments each BUSY cycle.
//    - If it reaches TIMEOUT_CYCLES-1 with bus_ack=0: bus_req_o<=0, rdata<=0, err<=1, goto RESP.
//    - The requester sees ack_o=1 with err_o=1. A bus_ack arriving later is ignored.
//  - BUS_TIMEOUT_EN undefined:
//    - No counter. BUSY waits indefinitely.
//    - if_err_o and mem_err_o are tied to 0. TIMEOUT_CYCLES is unused.
// TESTING
//  - Reset check: assert rst async mid-cycle -> all outputs 0 immediately, state IDLE.
//  - IF fetch: if_req=1, if_addr=0xBFC00000, bus acks in cycle 1 with 0x3C080001.
//    -> bus_sel_o=4'hF; if_ack_o pulses at cycle 2 with if_rdata_o=0x3C080001; stall_if_o low at cycle 2.
//  - Contention: if_req & mem_req (write 0x80000010, data 0xDEADBEEF, sel 4'h3) same cycle.
//    -> MEM is granted first (bus_we_o=1, bus_sel_o=4'h3).
//    -> The IF bus_req_o rises only after mem_ack_o. IF stalled throughout.
//  - Wait states: bus_ack delayed 5 cycles -> bus_*_o stable for all 5 cycles; ack exactly once.
//  - Flush: if_flush pulsed during BUSY_IF -> the bus completes but if_ack_o never asserts.
//    A subsequent fetch is acked normally.
//  - Timeout (BUS_TIMEOUT_EN, TIMEOUT_CYCLES=4): bus_ack never arrives.
//    -> bus_req_o drops after 4 BUSY cycles; mem_ack_o=1, mem_err_o=1, mem_rdata_o=0.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Shares one external memory port between instruction fetch and the MEM stage, with fixed MEM priority.
// Optional bus watchdog: define BUS_TIMEOUT_EN to abort a BUSY state after TIMEOUT_CYCLES cycles.
module mem_bus_arbiter #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic [31:0] if_rdata_o,
  output logic        if_ack_o,
  output logic        if_err_o,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [3:0]  mem_sel,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ack_o,
  output logic        mem_err_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        stall_if_o,
  output logic        stall_mem_o
);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MEM, RESP} state_t;

  state_t      state;
  logic        flush_pend;
  logic        tmo;
  logic        done;
  logic        if_drop;
  logic [31:0] rsp_data;

`ifdef BUS_TIMEOUT_EN
  localparam int CW = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
  logic [CW-1:0] cnt;
  assign tmo = ~bus_ack & (cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  logic unused_cfg;
  assign unused_cfg = (TIMEOUT_CYCLES != 0);
  assign tmo        = 1'b0;
  assign if_err_o   = 1'b0;
  assign mem_err_o  = 1'b0;
`endif

  assign done     = bus_ack | tmo;
  // Writes and timeouts return zero data.
  assign rsp_data = (bus_ack & ~bus_we_o) ? bus_rdata : 32'h0;
  // A flush landing in the completion cycle itself still kills the fetch result.
  assign if_drop  = flush_pend | if_flush;

  assign stall_if_o  = if_req & ~if_ack_o;
  assign stall_mem_o = mem_req & ~mem_ack_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      flush_pend  <= 1'b0;
      if_rdata_o  <= '0;
      if_ack_o    <= 1'b0;
      mem_rdata_o <= '0;
      mem_ack_o   <= 1'b0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_sel_o   <= '0;
      bus_addr_o  <= '0;
      bus_wdata_o <= '0;
`ifdef BUS_TIMEOUT_EN
      cnt         <= '0;
      if_err_o    <= 1'b0;
      mem_err_o   <= 1'b0;
`endif
    end else begin
      if_ack_o  <= 1'b0;
      mem_ack_o <= 1'b0;
      case (state)
        IDLE: begin
          if (mem_req) begin
            state       <= BUSY_MEM;
            bus_req_o   <= 1'b1;
            bus_we_o    <= mem_we;
            bus_sel_o   <= mem_sel;
            bus_addr_o  <= mem_addr;
            bus_wdata_o <= mem_wdata;
          end else if (if_req) begin
            state       <= BUSY_IF;
            bus_req_o   <= 1'b1;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= 4'hF;
            bus_addr_o  <= if_addr;
            bus_wdata_o <= '0;
          end
`ifdef BUS_TIMEOUT_EN
          cnt <= '0;
`endif
        end
        BUSY_IF, BUSY_MEM: begin
          if (state == BUSY_IF && if_flush) flush_pend <= 1'b1;
          if (done) begin
            bus_req_o <= 1'b0;
            state     <= RESP;
            if (state == BUSY_MEM) begin
              mem_ack_o   <= 1'b1;
              mem_rdata_o <= rsp_data;
`ifdef BUS_TIMEOUT_EN
              mem_err_o   <= tmo;
`endif
            end else if (!if_drop) begin
              if_ack_o   <= 1'b1;
              if_rdata_o <= rsp_data;
`ifdef BUS_TIMEOUT_EN
              if_err_o   <= tmo;
`endif
            end
          end
`ifdef BUS_TIMEOUT_EN
          else cnt <= cnt + 1'b1;
`endif
        end
        RESP: begin
          flush_pend <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
